harmonic_synth: RTL and testbench
=================================

Name: harmonic_synth

Overview:
- Additive resynthesizer; runs in the opposite direction to the FFT harmonic extractor.
- Consumes the 5-harmonic complex coefficient set produced by the analysis path: a single-cycle valid pulse plus packed {re,im} words.
- Regenerates a 16-bit PCM stream at a fixed sample rate by summing five phase-locked cosine/sine terms, for playback and loopback verification of the analysis chain.

Parameters:
- SAMPLE_PERIOD, 2083: clk_in cycles per output sample (100 MHz / ~48 kHz); minimum 16.
- OUT_SHIFT, 3: extra arithmetic right shift applied after the fixed >>>15 product normalisation.
- LUT_FILE, "sine256.mem": init file for a 256x16 signed sine ROM; entry i = round(32767*sin(2*pi*i/256)).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- data_valid_in  input  1  single-cycle pulse; coefficient set and phase_inc_in are valid on this cycle
- top_5_harmonic_coeffs  input  [4:0][31:0]  index k holds harmonic k+1 as {re[31:16], im[15:0]}, both signed Q15
- phase_inc_in  input  16  fundamental phase step per sample (2^16 = one cycle); sampled on data_valid_in
- sample_out  output  16  signed PCM sample; held between updates
- sample_valid_out  output  1  single-cycle high when sample_out updates
- busy_out  output  1  high from the first accepted set until reset

Behaviour:
- Clock and reset: one clock (clk_in); synchronous, active-high reset (rst_in).
- Reset values:
  - sample_out=0, sample_valid_out=0, busy_out=0.
  - Phase accumulator, tick counter, accumulator, working set, pending set and pending flag all 0.
  - State IDLE.
  - A reset mid-computation aborts the sample; no sample_valid_out is issued.
- States:
  - IDLE: wait for data_valid_in.
  - RUN_WAIT: tick counter counting.
  - ACC: 10 cycles.
  - OUT: 1 cycle.
- IDLE -> RUN_WAIT on the first data_valid_in:
  - Copy the set to the working registers.
  - phase_acc=0, tick counter=0, busy_out=1 the next cycle.
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - A tick occurs when the count equals SAMPLE_PERIOD-1.
  - Keeps counting in every non-IDLE state, so sample spacing is exactly SAMPLE_PERIOD.
  - First tick is SAMPLE_PERIOD cycles after acceptance.
- RUN_WAIT -> ACC on tick:
  - If the pending flag is set, copy the pending set into the working set on this cycle and clear the flag.
  - Clear the accumulator.
  - h_phase=phase_acc.
- ACC, 10 cycles, in order: k=0 cos, k=0 sin, k=1 cos, ... k=4 sin.
  - Cos cycle: acc += re_k * LUT[(h_phase[15:8]+64) mod 256].
  - Sin cycle: acc -= im_k * LUT[h_phase[15:8]]; then h_phase += phase_acc, mod 2^16, giving harmonic k+2 phase = (k+2)*phase_acc.
  - Products are 16x16 signed = 32 bits; the accumulator is 40-bit signed with no overflow.
- OUT:
  - sample_out = saturate16(acc >>> (15+OUT_SHIFT)), using arithmetic (floor) shift and clamping to [-32768, 32767].
  - sample_valid_out=1 for this one cycle.
  - phase_acc += phase_inc_working, mod 2^16.
  - Return to RUN_WAIT.
- Latency: sample_valid_out is asserted exactly 12 cycles after the tick cycle.
- data_valid_in while busy:
  - Captured into the pending set (coefficients and phase_inc) and sets the pending flag.
  - A later pulse before consumption overwrites the pending set (last wins).
  - A pulse on the same cycle as a tick is captured to pending and used from the next sample; the current sample uses the prior set.
  - Pending updates never reset phase_acc (phase-continuous).
- ROM read is combinational or registered; either choice must meet the 12-cycle latency.

Optional Feature:
- Macro: HARM_SYNTH_DECAY_EN.
- When defined:
  - An 8-bit envelope env is set to 255 whenever a set is applied to the working registers.
  - env decrements by 1 on each OUT cycle, stopping at 0.
  - Output = saturate16(((acc >>> (15+OUT_SHIFT)) * env) >>> 8).
  - The extra multiply stage makes latency 13 cycles.
- When undefined: no envelope and latency 12.
- Reset clears env to 0 in both builds.

Test Plan:
- Reset behaviour: assert rst_in with no data_valid_in for 5*SAMPLE_PERIOD -> sample_out=0, sample_valid_out never high, busy_out=0.
- Constant output: SAMPLE_PERIOD=16; coeff[0]={16'h4000,16'h0000}, others 0; phase_inc_in=0; pulse at cycle T -> busy_out=1 at T+1; first sample_valid_out at T+16+12; every sample 2047, spaced 16 cycles.
- Quarter-cycle step: same set with phase_inc_in=16'h4000 -> samples 2047, 0, -2048, 0, 2047 repeating.
- Saturation: OUT_SHIFT=0; all five re=16'h7FFF, im=16'h8000, phase_inc=0 -> acc=5368381445; sample_out=32767. Negate re (16'h8001) -> -32768.
- Pending update: pulse a new set (coeff[0].re=16'h2000) mid-ACC, then a second pulse with 16'h1000 before the tick -> the current sample uses the old set (2047); the next sample uses 16'h1000 (511); phase_acc continuous.
- Reset mid-operation: assert rst_in during ACC cycle 5 -> no sample_valid_out for that sample; all outputs 0 next cycle; IDLE until the next data_valid_in.

Source files
------------

// File: rtl/harmonic_synth.sv
// harmonic_synth: additive resynthesis of five complex harmonics into a fixed-rate 16-bit PCM stream.
// Define HARM_SYNTH_DECAY_EN to apply a decaying envelope per applied coefficient set (adds one cycle of latency).
module harmonic_synth #(
  parameter int SAMPLE_PERIOD = 2083,
  parameter int OUT_SHIFT = 3,
  parameter logic [255:0] LUT_FILE = "sine256.mem"
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            data_valid_in,
  input  logic [4:0][31:0] top_5_harmonic_coeffs,
  input  logic [15:0]     phase_inc_in,
  output logic [15:0]     sample_out,
  output logic            sample_valid_out,
  output logic            busy_out
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);
  // ROM holds the same round(32767*sin) table as LUT_FILE, built at elaboration so no data file is needed
  function automatic logic [4095:0] gen_lut();
    logic [4095:0] t;
    longint q, x, x2, p, s;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      q = longint'(i % 128);
      q = q > 64 ? 64'sd128 - q : q;
      x = 64'sd3373259426 * q / 64'sd128;
      x2 = (x * x) >>> 30;
      p = 64'sd1 << 30;
      for (int n = 6; n > 0; n--)
        p = (64'sd1 << 30) - ((x2 * p) >>> 30) / longint'((2 * n) * (2 * n + 1));
      s = (((x * p) >>> 30) * 64'sd32767 + (64'sd1 << 29)) >>> 30;
      t[i * 16 +: 16] = i < 128 ? s[15:0] : 16'(-s);
    end
    return t;
  endfunction
  localparam logic [4095:0] LUT = gen_lut();
  logic unused_lut_file;
  assign unused_lut_file = |LUT_FILE;
  typedef enum logic [1:0] {IDLE, RUN_WAIT, ACC, OUT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] tick_cnt;
  logic [3:0] step;
  logic [4:0][31:0] coef_w, coef_p;
  logic [15:0] inc_w, inc_p, phase_acc, h_phase;
  logic pend, tick, start;
  logic signed [39:0] acc, acc_nx, shifted;
  logic [2:0] k;
  logic [7:0] addr;
  logic signed [15:0] coef, lut;
  logic signed [31:0] prod;
  logic signed [48:0] sat_in;
  logic [15:0] sat_out;
`ifdef HARM_SYNTH_DECAY_EN
  logic [7:0] env;
  logic signed [48:0] scaled;
  logic scaled_v;
`endif
  assign tick = tick_cnt == LAST;
  assign start = state == RUN_WAIT && tick;
  always_comb begin
    state_nx = state == IDLE ? (data_valid_in ? RUN_WAIT : IDLE)
             : state == RUN_WAIT ? (tick ? ACC : RUN_WAIT)
             : state == ACC ? (step == 4'd9 ? OUT : ACC) : RUN_WAIT;
  end
  // even steps are the cosine term of harmonic step/2, odd steps the sine term
  always_comb begin
    k = step[3:1];
    addr = step[0] ? h_phase[15:8] : h_phase[15:8] + 8'd64;
    coef = step[0] ? coef_w[k][15:0] : coef_w[k][31:16];
    lut = LUT[{addr, 4'h0} +: 16];
    prod = coef * lut;
    acc_nx = step[0] ? acc - 40'(prod) : acc + 40'(prod);
    shifted = acc >>> (15 + OUT_SHIFT);
`ifdef HARM_SYNTH_DECAY_EN
    sat_in = scaled >>> 8;
`else
    sat_in = 49'(shifted);
`endif
    sat_out = sat_in > 49'sd32767 ? 16'h7fff : sat_in < -49'sd32768 ? 16'h8000 : sat_in[15:0];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      tick_cnt <= '0;
      step <= '0;
      coef_w <= '0;
      coef_p <= '0;
      inc_w <= '0;
      inc_p <= '0;
      pend <= 1'b0;
      phase_acc <= '0;
      h_phase <= '0;
      acc <= '0;
      sample_out <= '0;
      sample_valid_out <= 1'b0;
      busy_out <= 1'b0;
`ifdef HARM_SYNTH_DECAY_EN
      env <= '0;
      scaled <= '0;
      scaled_v <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      tick_cnt <= state == IDLE || tick ? '0 : tick_cnt + CW'(1);
      pend <= state != IDLE && (data_valid_in || (pend && !start));
      if (state == IDLE && data_valid_in) begin
        coef_w <= top_5_harmonic_coeffs;
        inc_w <= phase_inc_in;
        busy_out <= 1'b1;
      end
      if (state != IDLE && data_valid_in) begin
        coef_p <= top_5_harmonic_coeffs;
        inc_p <= phase_inc_in;
      end
      if (start) begin
        acc <= '0;
        h_phase <= phase_acc;
        step <= '0;
        if (pend) begin
          coef_w <= coef_p;
          inc_w <= inc_p;
        end
      end
      if (state == ACC) begin
        acc <= acc_nx;
        step <= step + 4'd1;
        if (step[0]) h_phase <= h_phase + phase_acc;
      end
      if (state == OUT) phase_acc <= phase_acc + inc_w;
`ifdef HARM_SYNTH_DECAY_EN
      if ((state == IDLE && data_valid_in) || (start && pend)) env <= 8'd255;
      else if (state == OUT) env <= env == 8'd0 ? 8'd0 : env - 8'd1;
      if (state == OUT) scaled <= 49'(shifted) * 49'($signed({1'b0, env}));
      scaled_v <= state == OUT;
      sample_valid_out <= scaled_v;
      if (scaled_v) sample_out <= sat_out;
`else
      sample_valid_out <= state == OUT;
      if (state == OUT) sample_out <= sat_out;
`endif
    end
  end
endmodule

// File: tb/tb_harmonic_synth.sv
// tb_harmonic_synth: directed and randomized checks of harmonic_synth against a coefficient/phase-level model.
// Two instances share stimulus: OUT_SHIFT=3 (normal range) and OUT_SHIFT=0 (saturation).
module tb_harmonic_synth;
  localparam int SP = 16;
  typedef struct packed { logic [4:0][31:0] c; logic [15:0] inc; } set_t;
  typedef struct { int cyc; set_t s; } pulse_t;
  logic clk_in = 1'b0, rst_in = 1'b1, data_valid_in = 1'b0;
  logic [4:0][31:0] coeffs = '0;
  logic [15:0] phase_inc_in = '0;
  logic [15:0] s3, s0;
  logic v3, v0, b3, b0;
  int tbl [256];
  int cyc = 0, compared = 0, mismatched = 0, next_v = 0;
  bit running = 1'b0;
  set_t cur;
  pulse_t q [$];
  logic [15:0] phase = '0, exp3 = '0, exp0 = '0;

  harmonic_synth #(.SAMPLE_PERIOD(SP), .OUT_SHIFT(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
    .top_5_harmonic_coeffs(coeffs), .phase_inc_in(phase_inc_in),
    .sample_out(s3), .sample_valid_out(v3), .busy_out(b3));
  harmonic_synth #(.SAMPLE_PERIOD(SP), .OUT_SHIFT(0)) dut_sat (
    .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
    .top_5_harmonic_coeffs(coeffs), .phase_inc_in(phase_inc_in),
    .sample_out(s0), .sample_valid_out(v0), .busy_out(b0));

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sum of (k+1)th-harmonic cos/sin terms at an 8-bit table phase, floor-scaled and clamped
  function automatic logic [15:0] model(input set_t s, input logic [15:0] ph, input int sh);
    longint sum;
    logic [7:0] a;
    sum = 0;
    for (int k = 0; k < 5; k++) begin
      a = 8'(((k + 1) * ph) >> 8);
      sum += longint'($signed(s.c[k][31:16])) * tbl[8'(a + 8'd64)]
           - longint'($signed(s.c[k][15:0])) * tbl[a];
    end
    sum = sum >>> (15 + sh);
    return sum > 32767 ? 16'h7fff : sum < -32768 ? 16'h8000 : 16'(sum);
  endfunction

  task automatic step();
    logic r = rst_in;
    logic d = data_valid_in;
    set_t in_s = {coeffs, phase_inc_in};
    logic ev = 1'b0;
    @(posedge clk_in);
    #1;
    cyc++;
    if (r) begin
      running = 1'b0;
      q.delete();
      exp3 = '0;
      exp0 = '0;
    end else if (d && !running) begin
      running = 1'b1;
      cur = in_s;
      phase = '0;
      next_v = cyc - 1 + SP + 12;
    end else if (d) q.push_back('{cyc - 1, in_s});
    if (running && cyc == next_v) begin
      while (q.size() > 0 && q[0].cyc < next_v - 12) begin
        cur = q[0].s;
        void'(q.pop_front());
      end
      exp3 = model(cur, phase, 3);
      exp0 = model(cur, phase, 0);
      phase += cur.inc;
      next_v += SP;
      ev = 1'b1;
    end
    chk("valid", v3, ev);
    chk("valid_sat", v0, ev);
    chk("sample", s3, exp3);
    chk("sample_sat", s0, exp0);
    chk("busy", b3, running);
    chk("busy_sat", b0, running);
  endtask

  task automatic pulse(input set_t s);
    coeffs = s.c;
    phase_inc_in = s.inc;
    data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
  endtask

  task automatic wait_sample();
    int n = 0;
    do begin
      step();
      n++;
    end while (!v3 && n < 4 * SP);
    chk("sample_timeout", v3, 1);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (2) step();
    rst_in = 1'b0;
    step();
  endtask

  function automatic set_t one(input logic [15:0] re, input logic [15:0] inc);
    set_t s = '0;
    s.c[0] = {re, 16'h0000};
    s.inc = inc;
    return s;
  endfunction

  function automatic set_t rnd();
    set_t s;
    for (int k = 0; k < 5; k++) s.c[k] = $urandom;
    s.inc = 16'($urandom);
    return s;
  endfunction

  initial begin
    real r;
    int t1, k;
    set_t s;
    logic [15:0] ql [6];
    for (int i = 0; i < 256; i++) begin
      r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * i / 256.0);
      tbl[i] = r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    end
    repeat (5 * SP) step();
    rst_in = 1'b0;
    repeat (3) step();
    pulse(one(16'h4000, 16'h0000));
    t1 = cyc;
    chk("busy_after_accept", b3, 1);
    wait_sample();
    chk("first_latency", cyc - t1, SP + 11);
    chk("const_first", s3, 16'd2047);
    repeat (3) begin
      wait_sample();
      chk("const", s3, 16'd2047);
    end
    do_reset();
    pulse(one(16'h4000, 16'h4000));
    ql = '{16'd2047, 16'd0, 16'hf800, 16'd0, 16'd2047, 16'd0};
    for (int i = 0; i < 6; i++) begin
      wait_sample();
      chk("quarter", s3, ql[i]);
    end
    do_reset();
    s = '0;
    for (int i = 0; i < 5; i++) s.c[i] = 32'h7fff_8000;
    pulse(s);
    wait_sample();
    chk("sat_pos", s0, 16'h7fff);
    chk("sat_pos_shift3", s3, 16'd20478);
    do_reset();
    for (int i = 0; i < 5; i++) s.c[i] = 32'h8001_8000;
    pulse(s);
    wait_sample();
    chk("sat_neg", s0, 16'h8000);
    chk("sat_neg_shift3", s3, 16'hb001);
    do_reset();
    pulse(one(16'h4000, 16'h0000));
    wait_sample();
    repeat (8) step();
    pulse(one(16'h2000, 16'h0000));
    repeat (4) step();
    pulse(one(16'h1000, 16'h0000));
    wait_sample();
    chk("pend_old_set", s3, 16'd2047);
    wait_sample();
    chk("pend_last_wins", s3, 16'd511);
    do_reset();
    pulse(one(16'h4000, 16'h0000));
    wait_sample();
    repeat (9) step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    chk("midrst_sample", s3, 0);
    chk("midrst_valid", v3, 0);
    chk("midrst_busy", b3, 0);
    repeat (3 * SP) step();
    chk("midrst_idle", b3, 0);
    pulse(one(16'h2000, 16'h0000));
    wait_sample();
    chk("restart", s3, 16'd1023);
    for (int rr = 0; rr < 4; rr++) begin
      do_reset();
      pulse(rnd());
      for (int i = 0; i < 6; i++) begin
        wait_sample();
        k = i == 0 ? 4 : int'($urandom_range(0, 14));
        if (i == 0 || $urandom_range(0, 1) == 1) begin
          repeat (k) step();
          pulse(rnd());
        end
      end
      wait_sample();
    end
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
